// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sequencer state encodings and sizing helpers
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEEP = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  localparam int SAMPLE_W_DEFAULT = 32;

  // Width needed to hold the values 0..n inclusive
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/countdown_beep_sequencer_if.sv
// rtl/countdown_beep_sequencer_if.sv - control/status/sample bundle of the beep sequencer
interface countdown_beep_sequencer_if
  import audio_pkg::*;
#(
  parameter int NUM_BEEPS = 6,
  parameter int SAMPLE_W  = SAMPLE_W_DEFAULT
);
  localparam int IDX_W = cnt_width(NUM_BEEPS);

  logic                       start;
  logic                       abort;
  logic                       repeat_en;
  logic [2:0]                 vol_shift;
  logic                       busy;
  logic                       beep_on;
  logic [IDX_W-1:0]           beep_idx;
  logic                       done;
  logic signed [SAMPLE_W-1:0] sample;

  modport master (
    output start, abort, repeat_en, vol_shift,
    input  busy, beep_on, beep_idx, done, sample
  );

  modport slave (
    input  start, abort, repeat_en, vol_shift,
    output busy, beep_on, beep_idx, done, sample
  );

endinterface

// File: rtl/square_tone_gen.sv
// rtl/square_tone_gen.sv - half-period counter and phase flop for a square tone
// phase shows the level the tone holds in the coming cycle, so the caller can register it.
module square_tone_gen #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] half_period,
  output logic         phase
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         phase_q;
  logic         phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (enable) begin
      if (cnt_q >= half_period - W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_d;

endmodule

// File: rtl/countdown_beep_sequencer.sv
// rtl/countdown_beep_sequencer.sv - countdown cue: NUM_BEEPS square-wave beeps, final "GO" beep
module countdown_beep_sequencer
  import audio_pkg::*;
#(
  parameter int NUM_BEEPS      = 6,
  parameter int BEEP_LEN       = 25_000_000,
  parameter int GAP_LEN        = 15_000_000,
  parameter int LAST_LEN       = 35_000_000,
  parameter int TONE_HALF      = 40_000,
  parameter int LAST_TONE_HALF = 20_000,
  parameter int AMPLITUDE      = 50_000_000,
  parameter int SAMPLE_W       = SAMPLE_W_DEFAULT,
  parameter int TIMER_W        = 32
) (
  input logic                        CLOCK_50,
  input logic                        resetn,
  countdown_beep_sequencer_if.slave  bus
);

  localparam int IDX_W = cnt_width(NUM_BEEPS);
  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(NUM_BEEPS);
  localparam logic signed [SAMPLE_W-1:0] AMP_POS  = SAMPLE_W'(AMPLITUDE);
  localparam logic signed [SAMPLE_W-1:0] AMP_NEG  = -AMP_POS;

  seq_state_t                 state;
  logic [TIMER_W-1:0]         timer;
  logic                       timer_done;
  logic                       is_last;
  logic                       tone_clear;
  logic                       tone_en;
  logic                       beep_on_nxt;
  logic                       tone_phase;
  logic [TIMER_W-1:0]         tone_half;
  logic signed [SAMPLE_W-1:0] tone_level;
  logic signed [SAMPLE_W-1:0] tone_scaled;
  logic [IDX_W-1:0]           idx_after_gap;

  // Timer is loaded with length-1 so a phase of length N lasts N cycles
  function automatic logic [TIMER_W-1:0] beep_load(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? TIMER_W'(LAST_LEN - 1) : TIMER_W'(BEEP_LEN - 1);
  endfunction

  assign timer_done    = (timer == '0);
  assign is_last       = (bus.beep_idx == LAST_IDX);
  assign idx_after_gap = is_last ? IDX_W'(1) : bus.beep_idx + IDX_W'(1);
  assign tone_half     = is_last ? TIMER_W'(LAST_TONE_HALF) : TIMER_W'(TONE_HALF);

  // Beep entry and continuation, decided one cycle ahead so the sample register lines up
  assign tone_clear  = !bus.abort && (((state == ST_IDLE) && bus.start) ||
                                      ((state == ST_GAP) && timer_done));
  assign tone_en     = !bus.abort && (state == ST_BEEP) && !timer_done;
  assign beep_on_nxt = tone_clear || tone_en;

  square_tone_gen #(.W(TIMER_W)) u_tone (
    .clk         (CLOCK_50),
    .rst_n       (resetn),
    .clear       (tone_clear),
    .enable      (tone_en),
    .half_period (tone_half),
    .phase       (tone_phase)
  );

  assign tone_level  = tone_phase ? AMP_POS : AMP_NEG;
  assign tone_scaled = tone_level >>> bus.vol_shift;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      timer        <= '0;
      bus.busy     <= 1'b0;
      bus.beep_on  <= 1'b0;
      bus.beep_idx <= '0;
      bus.done     <= 1'b0;
      bus.sample   <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.sample <= beep_on_nxt ? tone_scaled : '0;
      if (bus.abort) begin
        state        <= ST_IDLE;
        timer        <= '0;
        bus.busy     <= 1'b0;
        bus.beep_on  <= 1'b0;
        bus.beep_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state        <= ST_BEEP;
              timer        <= beep_load(IDX_W'(1));
              bus.busy     <= 1'b1;
              bus.beep_on  <= 1'b1;
              bus.beep_idx <= IDX_W'(1);
            end
          end
          ST_BEEP: begin
            if (!timer_done) begin
              timer <= timer - TIMER_W'(1);
            end else if (is_last && !bus.repeat_en) begin
              state        <= ST_IDLE;
              timer        <= '0;
              bus.done     <= 1'b1;
              bus.busy     <= 1'b0;
              bus.beep_on  <= 1'b0;
              bus.beep_idx <= '0;
            end else begin
              state       <= ST_GAP;
              timer       <= TIMER_W'(GAP_LEN - 1);
              bus.done    <= is_last;
              bus.beep_on <= 1'b0;
            end
          end
          ST_GAP: begin
            if (!timer_done) begin
              timer <= timer - TIMER_W'(1);
            end else begin
              state        <= ST_BEEP;
              timer        <= beep_load(idx_after_gap);
              bus.beep_on  <= 1'b1;
              bus.beep_idx <= idx_after_gap;
            end
          end
          default: begin
            state        <= ST_IDLE;
            timer        <= '0;
            bus.busy     <= 1'b0;
            bus.beep_on  <= 1'b0;
            bus.beep_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule
